// File: rtl/ldpc_wb_stream_bridge.sv
// Wishbone slave bridge: firmware words go through a TX FIFO to the LDPC core.
// Core results come back through an RX FIFO for readout, with a result-pending irq.
module ldpc_wb_stream_bridge #(
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          DEPTH_LOG2 = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [2:0]  irq
);
    localparam int            DEPTH      = 1 << DEPTH_LOG2;
    localparam int            CW         = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam int            TXF        = 0;
    localparam int            RXF        = 1;

    logic               req;
    logic [1:0]         reg_sel;
    logic               wr_txdata, rd_rxdata, wr_ctrl, clear;
    logic               ack_reg, irq_reg, irq_en_reg, tx_ovf_reg, rx_unf_reg;
    logic [31:0]        dat_reg, rd_data, status_word;
    logic [1:0]         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0][31:0]   fifo_wdata, fifo_head;
    logic [1:0][CW-1:0] fifo_count;
    logic               unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // A request is only taken while no ack is outstanding, giving one ack per strobe.
    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_reg & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign reg_sel   = wbs_adr_i[3:2];
    assign wr_txdata = req & wbs_we_i & (reg_sel == 2'd0);
    assign rd_rxdata = req & ~wbs_we_i & (reg_sel == 2'd1);
    assign wr_ctrl   = req & wbs_we_i & (reg_sel == 2'd3);
    assign clear     = wr_ctrl & wbs_dat_i[1];

    always_comb begin
        fifo_pop   = '0;
        fifo_push  = '0;
        fifo_wdata = '0;
        fifo_pop[TXF]   = ~fifo_empty[TXF] & tx_ready;
        // A full TX FIFO still accepts a word when its head leaves on the same edge.
        fifo_push[TXF]  = wr_txdata & (~fifo_full[TXF] | fifo_pop[TXF]);
        fifo_wdata[TXF] = wbs_dat_i;
        fifo_push[RXF]  = rx_valid & ~fifo_full[RXF];
        fifo_pop[RXF]   = rd_rxdata & ~fifo_empty[RXF];
        fifo_wdata[RXF] = rx_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [31:0]           mem [DEPTH];
            logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0]         count_reg;

            always_ff @(posedge wb_clk_i) begin
                if (fifo_push[gi] & ~clear)
                    mem[wr_ptr_reg] <= fifo_wdata[gi];
            end

            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (clear) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (fifo_push[gi])
                        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
                    if (fifo_pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
                    count_reg <= count_reg + CW'(fifo_push[gi]) - CW'(fifo_pop[gi]);
                end
            end

            assign fifo_head[gi]  = mem[rd_ptr_reg];
            assign fifo_count[gi] = count_reg;
            assign fifo_full[gi]  = (count_reg == FULL_COUNT);
            assign fifo_empty[gi] = (count_reg == '0);
        end
    endgenerate

    assign status_word = {20'd0, 4'(fifo_count[RXF]), 4'(fifo_count[TXF]),
                          rx_unf_reg, tx_ovf_reg, fifo_empty[RXF], fifo_full[TXF]};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd1:    rd_data = fifo_empty[RXF] ? 32'd0 : fifo_head[RXF];
            2'd2:    rd_data = status_word;
            2'd3:    rd_data = {31'd0, irq_en_reg};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_reg    <= 1'b0;
            dat_reg    <= '0;
            irq_reg    <= 1'b0;
            irq_en_reg <= 1'b0;
            tx_ovf_reg <= 1'b0;
            rx_unf_reg <= 1'b0;
        end else begin
            ack_reg <= req;
            if (req & ~wbs_we_i)
                dat_reg <= rd_data;
            irq_reg <= irq_en_reg & ~fifo_empty[RXF];
            if (clear) begin
                tx_ovf_reg <= 1'b0;
                rx_unf_reg <= 1'b0;
            end else begin
                if (wr_txdata & fifo_full[TXF] & ~fifo_pop[TXF])
                    tx_ovf_reg <= 1'b1;
                if (rd_rxdata & fifo_empty[RXF])
                    rx_unf_reg <= 1'b1;
            end
            // A flush write leaves the interrupt enable as it was.
            if (wr_ctrl & ~wbs_dat_i[1])
                irq_en_reg <= wbs_dat_i[0];
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign tx_valid  = ~fifo_empty[TXF];
    assign tx_data   = fifo_empty[TXF] ? 32'd0 : fifo_head[TXF];
    assign rx_ready  = ~fifo_full[RXF];
    assign irq       = {2'b00, irq_reg};
endmodule

// File: tb/tb_ldpc_wb_stream_bridge.sv
// Bench for ldpc_wb_stream_bridge: directed steps plus random traffic, checked
// every cycle against a queue-based model of the register map and FIFOs.
module tb_ldpc_wb_stream_bridge;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = BASE, wdat = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [2:0]  irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        m_ovf, m_unf, m_irq_en, m_ack, m_irq;
    logic [31:0] m_dat;

    ldpc_wb_stream_bridge dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .tx_data  (tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data  (rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq      (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_ovf = 0; m_unf = 0; m_irq_en = 0; m_ack = 0; m_irq = 0; m_dat = '0;
    endtask

    function automatic logic [31:0] model_status();
        logic [3:0] txc, rxc;
        txc = 4'(tx_q.size());
        rxc = 4'(rx_q.size());
        return {20'd0, rxc, txc, m_unf, m_ovf, rx_q.size() == 0, tx_q.size() == DEPTH};
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_update();
        logic        req, tx_pop, rx_push, irq_next;
        logic [1:0]  s;
        logic [31:0] rd, rx_word;
        req      = cyc && stb && !m_ack && (adr[31:4] == BASE[31:4]);
        s        = adr[3:2];
        tx_pop   = (tx_q.size() != 0) && tx_ready;
        rx_push  = rx_valid && (rx_q.size() < DEPTH);
        rx_word  = rx_data;
        irq_next = m_irq_en && (rx_q.size() != 0);
        rd       = m_dat;
        if (req && !we) begin
            case (s)
                2'd0: rd = 32'd0;
                2'd1: rd = (rx_q.size() != 0) ? rx_q[0] : 32'd0;
                2'd2: rd = model_status();
                default: rd = {31'd0, m_irq_en};
            endcase
        end
        if (tx_pop) void'(tx_q.pop_front());
        if (req && we && s == 2'd0) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(wdat);
            else m_ovf = 1;
        end
        if (req && !we && s == 2'd1) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else m_unf = 1;
        end
        if (rx_push) rx_q.push_back(rx_word);
        if (req && we && s == 2'd3) begin
            if (wdat[1]) begin
                tx_q.delete(); rx_q.delete(); m_ovf = 0; m_unf = 0;
            end else begin
                m_irq_en = wdat[0];
            end
        end
        m_ack = req;
        m_dat = rd;
        m_irq = irq_next;
    endtask

    task automatic check_outputs();
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() != 0});
        if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, rx_q.size() < DEPTH});
        chk("ack", {31'd0, wbs_ack_o}, {31'd0, m_ack});
        chk("dat_o", wbs_dat_o, m_dat);
        chk("irq", {29'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic cycle();
        check_outputs();
        model_update();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        cycle();
        cyc = 0; stb = 0; we = 0;
        cycle();
    endtask

    initial begin
        int s;
        model_reset();
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("reset_dat", wbs_dat_o, 32'd0);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_tx_data", tx_data, 32'd0);
        chk("reset_irq", {29'd0, irq}, 32'd0);
        wb_rst_i = 0;

        // 1: idle status
        wb_req(0, BASE + 32'h8, 0);
        chk("status_idle", wbs_dat_o, 32'h0000_0002);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // 2: overfill TX, then drain
        for (int i = 0; i < 9; i++) wb_req(1, BASE, 32'hA0 + 32'(i));
        wb_req(0, BASE + 32'h8, 0);
        chk("status_tx_full_ovf", wbs_dat_o, 32'h0000_0087);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_stream_word", tx_data, 32'hA0 + 32'(i));
            cycle();
        end
        chk("tx_drained", {31'd0, tx_valid}, 32'd0);
        tx_ready = 0;

        // 3: fill RX, read out, underflow
        rx_valid = 1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 32'h100 + 32'(i);
            chk("rx_ready_fill", {31'd0, rx_ready}, 32'd1);
            cycle();
        end
        rx_valid = 0;
        chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            wb_req(0, BASE + 32'h4, 0);
            chk("rx_read_word", wbs_dat_o, 32'h100 + 32'(i));
        end
        wb_req(0, BASE + 32'h4, 0);
        chk("rx_underflow_data", wbs_dat_o, 32'd0);
        wb_req(0, BASE + 32'h8, 0);
        chk("status_unf", wbs_dat_o, 32'h0000_000E);

        // 4: interrupt timing
        wb_req(1, BASE + 32'hC, 32'd1);
        rx_valid = 1; rx_data = 32'h55;
        cycle();
        rx_valid = 0;
        chk("irq_lag", {29'd0, irq}, 32'd0);
        cycle();
        chk("irq_rise", {29'd0, irq}, 32'd1);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4;
        cycle();
        chk("irq_after_pop_edge", {29'd0, irq}, 32'd1);
        chk("irq_word", wbs_dat_o, 32'h55);
        cyc = 0; stb = 0;
        cycle();
        chk("irq_fall", {29'd0, irq}, 32'd0);

        // 5: push into full TX alongside a pop, then flush
        for (int i = 0; i < 8; i++) wb_req(1, BASE, 32'hC0 + 32'(i));
        cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'hC8; tx_ready = 1;
        cycle();
        tx_ready = 0; cyc = 0; stb = 0; we = 0;
        cycle();
        wb_req(0, BASE + 32'h8, 0);
        chk("tx_count_push_pop", {28'd0, wbs_dat_o[7:4]}, 32'd8);
        chk("tx_head_after_pop", tx_data, 32'hC1);
        wb_req(1, BASE + 32'hC, 32'd2);
        wb_req(0, BASE + 32'h8, 0);
        chk("status_cleared", wbs_dat_o, 32'h0000_0002);
        wb_req(0, BASE + 32'hC, 0);
        chk("irq_en_kept", wbs_dat_o, 32'd1);

        // 6: foreign address, then reset mid-write
        wb_req(1, BASE + 32'h10, 32'hDEAD);
        wb_req(0, BASE + 32'h8, 0);
        chk("status_foreign", wbs_dat_o, 32'h0000_0002);
        cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'hBEEF;
        #2 wb_rst_i = 1;
        #1;
        chk("midrst_dat", wbs_dat_o, 32'd0);
        chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge wb_clk_i);
        #1;
        model_reset();
        wb_rst_i = 0; cyc = 0; stb = 0; we = 0;
        chk("midrst_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("midrst_tx_empty", {31'd0, tx_valid}, 32'd0);
        cycle();
        wb_req(0, BASE + 32'hC, 0);
        chk("midrst_irq_en", wbs_dat_o, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (stb) begin
                cyc = 0; stb = 0; we = 0;
            end else if ($urandom_range(1, 0) == 1) begin
                s    = int'($urandom_range(3, 0));
                we   = 1'($urandom_range(1, 0));
                sel  = 4'($urandom);
                adr  = BASE + 32'(s * 4);
                if ($urandom_range(7, 0) == 0) adr = adr ^ 32'h0000_0100;
                wdat = $urandom;
                if (s == 3) wdat = {30'd0, $urandom_range(7, 0) == 0, 1'($urandom_range(1, 0))};
                cyc = 1; stb = 1;
            end
            tx_ready = 1'($urandom_range(1, 0));
            rx_valid = 1'($urandom_range(1, 0));
            rx_data  = $urandom;
            cycle();
        end
        cyc = 0; stb = 0; we = 0; tx_ready = 0; rx_valid = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ldpc_wb_stream_bridge.md
# ldpc_wb_stream_bridge

Wishbone-slave bridge between the Caravel management SoC bus and the `ldpcEncDec` core datapath. It buffers 32-bit words written by firmware in a TX FIFO and streams them to the encoder/decoder input with valid/ready. It collects result words from the core in an RX FIFO for firmware readout. It raises an interrupt on `irq[0]` while results are pending.

## Interface
Parameters:
- `ADDR_BASE`, default `32'h3000_0000`: base address; the block decodes `wbs_adr_i[31:4] == ADDR_BASE[31:4]`.
- `DEPTH_LOG2`, default 3: each FIFO holds `2**DEPTH_LOG2` words (8 by default).

Ports:
- `wb_clk_i`  in  1  single clock; all logic is on the rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle controls.
- `wbs_sel_i`  in  4  byte selects; ignored, so every access is treated as a full word.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  registered read data.
- `tx_data`  out  32  word to the core; shows the TX FIFO head (first-word fall-through).
- `tx_valid`  out  1  TX FIFO is not empty.
- `tx_ready`  in  1  core accepts `tx_data`.
- `rx_data`  in  32  result word from the core.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  RX FIFO is not full.
- `irq`  out  3  bit 0 is the result-pending interrupt; bits 2:1 are tied to 0.

## Operation
Register map, selected by `wbs_adr_i[3:2]`:
- **0 TXDATA**
  - Write pushes `wbs_dat_i` into the TX FIFO.
  - Read returns 0.
- **1 RXDATA**
  - Read pops the RX FIFO head.
  - Write is ignored.
- **2 STATUS** (read-only)
  - [0] `tx_full`, [1] `rx_empty`.
  - [2] `tx_ovf`, sticky.
  - [3] `rx_unf`, sticky.
  - [7:4] `tx_count`, [11:8] `rx_count`.
  - All other bits are 0.
- **3 CTRL**
  - [0] `irq_en`: read/write.
  - [1] `clear`: write 1 to flush both FIFOs (pointers and counts to 0) and clear both sticky flags. It reads as 0.

FIFO behaviour:
- A push to a full TX FIFO drops the word and sets `tx_ovf`. The access is still acked.
- A pop from an empty RX FIFO returns 0 and sets `rx_unf`. The access is still acked.
- Pointers wrap modulo `2**DEPTH_LOG2`. Each count is `DEPTH_LOG2+1` bits, zero-extended into its STATUS field.
- Simultaneous push and pop on the same FIFO in one cycle:
  - Both take effect and the count is unchanged.
  - A push while full succeeds only if a pop happens in the same cycle.
  - A pop while empty never bypasses the concurrent push.
- `clear` takes priority over any push or pop in the same cycle.

Streaming side:
- A TX transfer occurs on any cycle where `tx_valid & tx_ready` is high.
- An RX transfer occurs on any cycle where `rx_valid & rx_ready` is high.
- `tx_data` must be held stable while `tx_valid` is high and `tx_ready` is low.

Interrupt: `irq[0]` is a register that loads `irq_en & ~rx_empty` every cycle.

Address handling: an access with a non-matching address gets no ack and has no side effects.

## Timing
Wishbone access:
- A request is taken in the first cycle N with `cyc & stb` high, address matching, and `wbs_ack_o` low.
- The write or pop takes effect at the N→N+1 edge.
- `wbs_ack_o` is high in cycle N+1 for exactly one cycle; `wbs_dat_o` is valid in the same cycle.
- The master drops `stb` after the ack, so the minimum spacing between requests is 2 cycles.
- `wbs_dat_o` holds its last value when not acking. It is sampled at cycle N, so an RXDATA read returns the head that existed at cycle N.

Latencies:
- A pushed word appears on `tx_valid`/`tx_data` in cycle N+1.
- An RX word accepted at edge E is visible in STATUS and poppable from the next request onwards.
- `irq[0]` follows `rx_empty` with one cycle of lag.

Reset:
- Asserting `wb_rst_i` immediately sets all outputs to 0: `wbs_ack_o`, `wbs_dat_o`, `tx_valid`, `tx_data`, `irq`.
- `rx_ready` goes to 1 (FIFO empty).
- All pointers, counts, `irq_en` and sticky flags go to 0.
- If reset is asserted mid-access, the access is aborted with no ack. A partially completed stream handshake is simply lost.

## Test plan
1. Reset, then read STATUS → `32'h0000_0002` (`rx_empty`=1). Outputs: `tx_valid`=0, `rx_ready`=1.
2. Write TXDATA 9 times (`32'hA0..A8`) with `tx_ready`=0.
   - STATUS shows `tx_count`=8, `tx_full`=1, `tx_ovf`=1.
   - Then raise `tx_ready`: the core receives `A0..A7` in order on 8 consecutive cycles.
3. Drive 8 RX words (`32'h100..107`) back-to-back.
   - `rx_ready` drops after the 8th word.
   - 8 RXDATA reads return `100..107`.
   - A 9th read returns 0 and sets `rx_unf`.
4. Set CTRL=1 (`irq_en`) with the RX FIFO empty, then push one RX word.
   - `irq[0]` rises one cycle after the RX transfer.
   - Popping that word drops `irq[0]` one cycle after the pop edge.
5. With the TX FIFO full and `tx_ready`=1, issue a TXDATA write in the same cycle as a pop.
   - The word is accepted and `tx_count` stays 8.
   - Then write CTRL=2: counts and sticky flags read 0, and `irq_en` is unchanged.
6. Access address `ADDR_BASE+32'h10` → no ack and no state change.
   - Assert reset mid-write → no ack and the FIFO is unchanged (empty).
